// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus memory-bus signals of the load/store unit.
// Latency: none, wires only.
// Backpressure: requester holds iReqValid and operands until oReqReady is high.
// Ports: request (iReqValid/oReqReady/iReqWrite/iFunct3/iAddress/iStoreData),
//        response (oRespValid/oLoadData/oError),
//        bus (oReadEnable/oWriteEnable/oByteEnable/oAddress/oWriteData/iReadData).
interface mem_access_unit_if;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [2:0]  iFunct3;
    logic [31:0] iAddress;
    logic [31:0] iStoreData;
    logic        oRespValid;
    logic [31:0] oLoadData;
    logic        oError;
    logic        oReadEnable;
    logic        oWriteEnable;
    logic [3:0]  oByteEnable;
    logic [31:0] oAddress;
    logic [31:0] oWriteData;
    logic [31:0] iReadData;

    // slave: the load/store unit itself
    modport slave (
        input  iReqValid, iReqWrite, iFunct3, iAddress, iStoreData, iReadData,
        output oReqReady, oRespValid, oLoadData, oError,
               oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData
    );

    // master: the execute stage plus the memory bus model
    modport master (
        output iReqValid, iReqWrite, iFunct3, iAddress, iStoreData, iReadData,
        input  oReqReady, oRespValid, oLoadData, oError,
               oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store initiator between execute stage and memory bus.
// Latency: store resp N+2, load resp N+READ_LATENCY+1, error resp N+1.
// Backpressure: one request in flight; oReqReady high only in IDLE.
// Ports: iCLK, iRST_N (sync active-low) plus mem_access_unit_if.slave bus.
// Optional: define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses; otherwise misaligned offsets are truncated to the natural alignment.
module mem_access_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;

    // request decode
    logic [1:0]  req_size;
    logic [1:0]  req_a;
    logic        req_err;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdat;

    always_comb begin
        req_size = bus.iFunct3[1:0];
        req_a    = bus.iAddress[1:0];
        if (bus.iReqWrite)
            req_err = (bus.iFunct3 > 3'd2);
        else
            req_err = (bus.iFunct3 == 3'd3) || (bus.iFunct3 >= 3'd6);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if ((req_size == 2'd1 && req_a[0]) || (req_size == 2'd2 && req_a != 2'd0))
            req_err = 1'b1;
`endif
        // Offsets are truncated to the access size; with the trap enabled
        // only aligned requests get here, so truncation is a no-op.
        case (req_size)
            2'd0: begin
                req_off  = req_a;
                req_be   = 4'b0001 << req_a;
                req_wdat = {4{bus.iStoreData[7:0]}};
            end
            2'd1: begin
                req_off  = {req_a[1], 1'b0};
                req_be   = req_a[1] ? 4'b1100 : 4'b0011;
                req_wdat = {2{bus.iStoreData[15:0]}};
            end
            default: begin
                req_off  = 2'd0;
                req_be   = 4'b1111;
                req_wdat = bus.iStoreData;
            end
        endcase
    end

    // load extraction from the bus word, using the latched offset/width
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = bus.iReadData[7:0];
            2'd1:    rd_byte = bus.iReadData[15:8];
            2'd2:    rd_byte = bus.iReadData[23:16];
            default: rd_byte = bus.iReadData[31:24];
        endcase
        rd_half = off_q[1] ? bus.iReadData[31:16] : bus.iReadData[15:0];
        case (funct3_q)
            3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
            3'd2:    rd_ext = bus.iReadData;
            3'd4:    rd_ext = {24'd0, rd_byte};
            3'd5:    rd_ext = {16'd0, rd_half};
            default: rd_ext = 32'd0;
        endcase
    end

    // next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdat_d   = wdat_q;
        load_d   = load_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.iReqValid) begin
                    write_d  = bus.iReqWrite;
                    funct3_d = bus.iFunct3;
                    off_d    = req_off;
                    addr_d   = {bus.iAddress[31:2], 2'b00};
                    be_d     = req_be;
                    wdat_d   = bus.iReqWrite ? req_wdat : 32'd0;
                    load_d   = 32'd0;
                    err_d    = req_err;
                    cnt_d    = LAT_M1;
                    // illegal requests skip the bus entirely
                    state_d  = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_d = RESP;
                end else if (cnt_q == 4'd0) begin
                    load_d  = rd_ext;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                load_d  = 32'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdat_q   <= 32'd0;
            load_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdat_q   <= wdat_d;
            load_q   <= load_d;
            err_q    <= err_d;
        end
    end

    // bus fields are gated so they read 0 outside ACCESS
    logic in_access;
    assign in_access        = (state_q == ACCESS);
    assign bus.oReqReady    = (state_q == IDLE);
    assign bus.oRespValid   = (state_q == RESP);
    assign bus.oLoadData    = (state_q == RESP) ? load_q : 32'd0;
    assign bus.oError       = (state_q == RESP) && err_q;
    assign bus.oReadEnable  = in_access && !write_q;
    assign bus.oWriteEnable = in_access && write_q;
    assign bus.oByteEnable  = in_access ? be_q : 4'd0;
    assign bus.oAddress     = in_access ? addr_q : 32'd0;
    assign bus.oWriteData   = in_access ? wdat_q : 32'd0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that sits between the core's execute stage and the memory bus.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the bus enables, byte lanes, word address and lane-aligned write data, then waits a fixed read latency.
- Returns load data extracted and sign- or zero-extended per RV32I funct3, plus an error flag.

Parameters:
- READ_LATENCY, 1, number of iCLK cycles the bus read enable is held before iReadData is sampled; legal range 1..15.

Ports:
- iCLK  input  1  core clock; all state updates on its rising edge.
- iRST_N  input  1  reset; synchronous, active-low.
- iReqValid  input  1  request present.
- oReqReady  output  1  unit can accept a request (high only in IDLE).
- iReqWrite  input  1  1 = store, 0 = load.
- iFunct3  input  3  RV32I width/sign code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- iAddress  input  32  byte address.
- iStoreData  input  32  store operand, value in the low bits.
- oRespValid  output  1  one-cycle response pulse.
- oLoadData  output  32  extended load result; 0 for stores and errors.
- oError  output  1  request rejected; valid with oRespValid.
- oReadEnable  output  1  bus read enable.
- oWriteEnable  output  1  bus write enable.
- oByteEnable  output  4  bus byte lanes; bit i = byte i of the word.
- oAddress  output  32  bus word address, iAddress with bits [1:0] forced to 0.
- oWriteData  output  32  lane-aligned store data.
- iReadData  input  32  bus read word.

Behaviour:
- Reset, when iRST_N is low at an edge:
  - State goes to IDLE and the latency counter clears.
  - All outputs are 0 except oReqReady = 1.
  - An in-flight access is abandoned: no response, bus enables low from the next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE to ACCESS: iReqValid && oReqReady at edge N (cycle N).
  - Address, funct3, write flag and the lane-computed fields are latched at that edge.
- IDLE to RESP: an illegal request goes directly to RESP at edge N and raises no bus enable. Illegal means:
  - Load funct3 of 3, 6 or 7.
  - Store funct3 of 3 to 7.
  - Misaligned access, when the trap feature is enabled.
- ACCESS, store:
  - oWriteEnable = 1 for exactly cycle N+1, then RESP.
- ACCESS, load:
  - oReadEnable = 1 for cycles N+1 .. N+READ_LATENCY.
  - iReadData is captured at the edge ending the last ACCESS cycle, then RESP.
- RESP:
  - oRespValid = 1 for one cycle, then IDLE.
  - Store response at cycle N+2; load response at cycle N+READ_LATENCY+1; error response at cycle N+1.
- oAddress, oByteEnable and oWriteData are held stable throughout ACCESS and are 0 outside ACCESS.
- Byte lanes, with a = address[1:0]:
  - Byte: oByteEnable = 4'b0001 << a.
  - Half: oByteEnable = 4'b0011 << (2*a[1]).
  - Word: oByteEnable = 4'b1111.
- Write data:
  - SB: byte replicated to all 4 lanes.
  - SH: half replicated to both halves.
  - SW: passed through unchanged.
- Load extraction:
  - Select byte a, or half a[1], of the captured word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- A request presented outside IDLE is ignored (oReqReady = 0); the requester must hold iReqValid and its operands.
- Back-to-back requests: the next request can be accepted in the cycle after RESP, so the minimum store throughput is one per 3 cycles.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Misaligned means: half access with a[0] = 1, or word access with a != 0.
- Defined: a misaligned request is an error with no bus activity. oError = 1 and oLoadData = 0 at cycle N+1.
- Undefined: misaligned requests proceed and oError never reflects alignment.
  - The low address bits are truncated: half uses a[1] only, word ignores a.
  - Lane selection and extraction follow the truncated offset.
- Illegal funct3 raises oError in both builds.

Test Plan:
- Reset mid-load:
  - Stimulus: LW to 0x10010000, READ_LATENCY = 3; drop iRST_N at N+2 for one cycle.
  - Required: oReadEnable = 0 from the following cycle, no oRespValid, oReqReady = 1.
- SB:
  - Stimulus: addr 0x10010003, data 0x000000A5.
  - Required: at N+1, oAddress = 0x10010000, oByteEnable = 4'b1000, oWriteData = 0xA5A5A5A5, oWriteEnable = 1. At N+2, oRespValid = 1 and oLoadData = 0.
- LH sign extension:
  - Stimulus: addr 0x10010002, iReadData = 0x8001_7FFF, READ_LATENCY = 1.
  - Required: oByteEnable = 4'b1100; at N+2, oLoadData = 0xFFFF8001. The same request as LHU returns 0x00008001.
- LBU then LB, back-to-back:
  - Stimulus: addr 0x00400001, iReadData = 0x0000F000.
  - Required: results 0x000000F0 and 0xFFFFFFF0; the second request is accepted exactly at the cycle after the first RESP.
- Misaligned SW to 0x10010002:
  - Trap build: oError = 1 at N+1 with no oWriteEnable.
  - Non-trap build: oByteEnable = 4'b1111 at address 0x10010000 and oError = 0.
- Load funct3 = 7:
  - Required: oError = 1 at N+1, no oReadEnable, oLoadData = 0, in both builds.
